rgb_fader: RTL and testbench

Per-channel brightness fader between the RGB blink generator and the LED pins. It takes the three on/off levels produced by `blink` and drives each LED with PWM whose duty ramps linearly: up while the input is high, down while it is low. The result is a hard blink rendered as a smooth breathe. It runs in the `blink` clock domain; its inputs connect directly to `o_led_r`/`o_led_g`/`o_led_b` of `blink`.

---
 rtl/rgb_fader_pkg.sv | 14 +
 rtl/fade_channel.sv | 58 +++++
 rtl/rgb_fader.sv | 71 +++++++
 tb/tb_rgb_fader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rgb_fader_pkg.sv
// rgb_fader_pkg: shared state encoding and default parameters for the RGB fader.
package rgb_fader_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } fade_state_e;

    localparam int DEF_PWM_BITS = 8;
    localparam int DEF_STEP_DIV = 1024;

endpackage

// File: rtl/fade_channel.sv
// fade_channel: one colour channel -- saturating level ramp, fade state, duty latch and PWM compare.
// Ports: i_clk/i_rst clock and async active-high reset; i_tgt registered target level;
//        i_tick fade step strobe; i_wrap last cycle of the PWM period; i_pwm_cnt shared PWM counter;
//        o_pwm registered PWM drive; o_busy channel is ramping (state UP or DOWN).
module fade_channel
    import rgb_fader_pkg::*;
#(
    parameter int p_pwm_bits = DEF_PWM_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tgt,
    input  logic                  i_tick,
    input  logic                  i_wrap,
    input  logic [p_pwm_bits-1:0] i_pwm_cnt,
    output logic                  o_pwm,
    output logic                  o_busy
);

    localparam logic [p_pwm_bits-1:0] MAX = '1;

    logic [p_pwm_bits-1:0] level_q, level_d;
    logic [p_pwm_bits-1:0] duty_q, duty_d;
    fade_state_e           state_q, state_d;
    logic                  pwm_q, pwm_d;

    always_comb begin
        level_d = level_q;
        if (i_tick && i_tgt && level_q != MAX)
            level_d = level_q + 1'b1;
        else if (i_tick && !i_tgt && level_q != '0)
            level_d = level_q - 1'b1;
        state_d = i_tgt ? ((level_d == MAX) ? ST_ON : ST_UP)
                        : ((level_d == '0) ? ST_OFF : ST_DOWN);
        // Latch the pre-update level so a tick coinciding with wrap shows up one period later.
        duty_d  = i_wrap ? level_q : duty_q;
        // Strict compare: full level still leaves one low cycle per period.
        pwm_d   = duty_q > i_pwm_cnt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            level_q <= '0;
            duty_q  <= '0;
            state_q <= ST_OFF;
            pwm_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            duty_q  <= duty_d;
            state_q <= state_d;
            pwm_q   <= pwm_d;
        end
    end

    assign o_pwm  = pwm_q;
    assign o_busy = (state_q == ST_UP) || (state_q == ST_DOWN);

endmodule

// File: rtl/rgb_fader.sv
// rgb_fader: turns three hard on/off LED levels into PWM outputs that fade linearly up and down.
// Ports: i_clk/i_rst clock and async active-high reset; i_led_r/g/b target levels from blink;
//        o_pwm_r/g/b PWM LED drive; o_busy any channel ramping (registered).
module rgb_fader
    import rgb_fader_pkg::*;
#(
    parameter int p_pwm_bits = DEF_PWM_BITS,
    parameter int p_step_div = DEF_STEP_DIV
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_led_r,
    input  logic i_led_g,
    input  logic i_led_b,
    output logic o_pwm_r,
    output logic o_pwm_g,
    output logic o_pwm_b,
    output logic o_busy
);

    localparam int              DW       = $clog2(p_step_div);
    localparam logic [DW-1:0]   DIV_LAST = DW'(p_step_div - 1);

    logic [2:0]            tgt_q, tgt_d;
    logic [DW-1:0]         div_q, div_d;
    logic [p_pwm_bits-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                  busy_q, busy_d;
    logic                  tick, wrap;
    logic [2:0]            ch_busy;

    always_comb begin
        tick      = div_q == DIV_LAST;
        wrap      = &pwm_cnt_q;
        tgt_d     = {i_led_b, i_led_g, i_led_r};
        div_d     = tick ? '0 : div_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        busy_d    = |ch_busy;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tgt_q     <= '0;
            div_q     <= '0;
            pwm_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            tgt_q     <= tgt_d;
            div_q     <= div_d;
            pwm_cnt_q <= pwm_cnt_d;
            busy_q    <= busy_d;
        end
    end

    fade_channel #(.p_pwm_bits(p_pwm_bits)) u_r (
        .i_clk(i_clk), .i_rst(i_rst), .i_tgt(tgt_q[0]), .i_tick(tick), .i_wrap(wrap),
        .i_pwm_cnt(pwm_cnt_q), .o_pwm(o_pwm_r), .o_busy(ch_busy[0])
    );

    fade_channel #(.p_pwm_bits(p_pwm_bits)) u_g (
        .i_clk(i_clk), .i_rst(i_rst), .i_tgt(tgt_q[1]), .i_tick(tick), .i_wrap(wrap),
        .i_pwm_cnt(pwm_cnt_q), .o_pwm(o_pwm_g), .o_busy(ch_busy[1])
    );

    fade_channel #(.p_pwm_bits(p_pwm_bits)) u_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_tgt(tgt_q[2]), .i_tick(tick), .i_wrap(wrap),
        .i_pwm_cnt(pwm_cnt_q), .o_pwm(o_pwm_b), .o_busy(ch_busy[2])
    );

    assign o_busy = busy_q;

endmodule

// File: tb/tb_rgb_fader.sv
// tb_rgb_fader: directed bench for rgb_fader with 4-bit PWM and a fade step every 4 cycles.
module tb_rgb_fader;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_led_r = 1'b0, i_led_g = 1'b0, i_led_b = 1'b0;
    logic o_pwm_r, o_pwm_g, o_pwm_b, o_busy;

    int total = 0;
    int bad   = 0;
    int ecnt;
    logic [3:0] prev_duty_r = '0, prev_duty_g = '0;

    rgb_fader #(.p_pwm_bits(4), .p_step_div(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_led_r(i_led_r), .i_led_g(i_led_g), .i_led_b(i_led_b),
        .o_pwm_r(o_pwm_r), .o_pwm_g(o_pwm_g), .o_pwm_b(o_pwm_b), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Rising edges since the last reset release.
    always @(posedge i_clk or posedge i_rst)
        if (i_rst) ecnt <= 0;
        else       ecnt <= ecnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Duty may only change on the edge that ends a PWM period, after which the counter reads 0.
    always @(negedge i_clk) begin
        if (!i_rst && dut.u_g.duty_q != prev_duty_g) check("duty_g_on_wrap", 32'(dut.pwm_cnt_q), 0);
        if (!i_rst && dut.u_r.duty_q != prev_duty_r) check("duty_r_on_wrap", 32'(dut.pwm_cnt_q), 0);
        prev_duty_g = dut.u_g.duty_q;
        prev_duty_r = dut.u_r.duty_q;
    end

    task automatic goto(input int k);
        while (ecnt < k) @(negedge i_clk);
    endtask

    task automatic do_reset(input logic r, input logic g, input logic b);
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        i_led_r = r;
        i_led_g = g;
        i_led_b = b;
        i_rst   = 1'b0;
    endtask

    task automatic count_pwm(input int n, output int hr, output int hg, output int hb);
        hr = 0; hg = 0; hb = 0;
        repeat (n) begin
            @(negedge i_clk);
            hr += int'(o_pwm_r);
            hg += int'(o_pwm_g);
            hb += int'(o_pwm_b);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hr, hg, hb;
        // Reset held with toggling inputs.
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            i_led_r = i[0];
            i_led_g = ~i[0];
            i_led_b = i[1];
        end
        check("rst_pwm", {29'd0, o_pwm_r, o_pwm_g, o_pwm_b}, 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_cnt", 32'(dut.pwm_cnt_q), 0);
        check("rst_states", {26'd0, dut.u_r.state_q, dut.u_g.state_q, dut.u_b.state_q}, 0);

        // Ramp up on red.
        i_led_r = 1'b1; i_led_g = 1'b0; i_led_b = 1'b0;
        i_rst = 1'b0;
        goto(1);
        check("up_cnt_first", 32'(dut.pwm_cnt_q), 1);
        check("up_tgt", 32'(dut.tgt_q), 1);
        goto(2);
        check("up_state_up", 32'(dut.u_r.state_q), 1);
        check("up_busy_lag", 32'(o_busy), 0);
        goto(3);
        check("up_busy", 32'(o_busy), 1);
        goto(59);
        check("up_level59", 32'(dut.u_r.level_q), 14);
        check("up_state59", 32'(dut.u_r.state_q), 1);
        goto(60);
        check("up_level60", 32'(dut.u_r.level_q), 15);
        check("up_state_on", 32'(dut.u_r.state_q), 2);
        check("up_busy60", 32'(o_busy), 1);
        goto(61);
        check("up_busy_fall", 32'(o_busy), 0);
        goto(80);
        count_pwm(16, hr, hg, hb);
        check("up_duty15", 32'(hr), 15);

        // Ramp down from ON.
        i_led_r = 1'b0;
        goto(97);
        check("dn_state97", 32'(dut.u_r.state_q), 2);
        goto(98);
        check("dn_state_down", 32'(dut.u_r.state_q), 3);
        goto(100);
        check("dn_level100", 32'(dut.u_r.level_q), 14);
        goto(155);
        check("dn_level155", 32'(dut.u_r.level_q), 1);
        goto(156);
        check("dn_level156", 32'(dut.u_r.level_q), 0);
        check("dn_state_off", 32'(dut.u_r.state_q), 0);
        check("dn_busy156", 32'(o_busy), 1);
        goto(157);
        check("dn_busy_fall", 32'(o_busy), 0);
        goto(160);
        count_pwm(16, hr, hg, hb);
        check("dn_pwm_zero", 32'(hr), 0);

        // Reversal on green.
        do_reset(1'b0, 1'b1, 1'b0);
        goto(20);
        check("rev_level20", 32'(dut.u_g.level_q), 5);
        i_led_g = 1'b0;
        goto(21);
        check("rev_state21", 32'(dut.u_g.state_q), 1);
        goto(22);
        check("rev_state_down", 32'(dut.u_g.state_q), 3);
        check("rev_level22", 32'(dut.u_g.level_q), 5);
        goto(24);
        check("rev_level24", 32'(dut.u_g.level_q), 4);
        goto(28);
        check("rev_level28", 32'(dut.u_g.level_q), 3);
        goto(50);
        check("rev_state50", 32'(dut.u_g.state_q), 0);

        // Independence: red and blue ramp, green stays off.
        do_reset(1'b1, 1'b0, 1'b1);
        goto(30);
        check("ind_level_r", 32'(dut.u_r.level_q), 7);
        check("ind_level_b", 32'(dut.u_b.level_q), 7);
        check("ind_state_g", 32'(dut.u_g.state_q), 0);
        check("ind_busy30", 32'(o_busy), 1);
        count_pwm(30, hr, hg, hb);
        check("ind_pwm_g", 32'(hg), 0);
        check("ind_pwm_rb", 32'(hr), 32'(hb));
        check("ind_busy60", 32'(o_busy), 1);
        check("ind_on", {28'd0, dut.u_r.state_q, dut.u_b.state_q}, 32'b1010);
        goto(61);
        check("ind_busy_fall", 32'(o_busy), 0);

        // Reset mid-ramp.
        do_reset(1'b1, 1'b0, 1'b0);
        goto(34);
        check("mid_level34", 32'(dut.u_r.level_q), 8);
        check("mid_pwm_hi", 32'(o_pwm_r), 1);
        #2 i_rst = 1'b1;
        #1;
        check("mid_async_pwm", 32'(o_pwm_r), 0);
        check("mid_async_level", 32'(dut.u_r.level_q), 0);
        check("mid_async_busy", 32'(o_busy), 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        goto(1);
        check("mid_cnt_first", 32'(dut.pwm_cnt_q), 1);
        check("mid_level1", 32'(dut.u_r.level_q), 0);
        goto(4);
        check("mid_level4", 32'(dut.u_r.level_q), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
